// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_pkg
// Description : Shared constants for the LFSR slice. It holds the tap table
//               for the supported widths, a lookup function that returns the
//               tap mask for a given width, and the value that the optional
//               zero guard forces into the register.
// Revision    : 1.0 - initial release
// ============================================================================
package lfsr_pkg;

    // Tap masks use 0-based state bits.
    // Polynomial exponent k maps to state bit k-1.
    localparam logic [63:0] c_tap_mask_8  = 64'h0000_0000_0000_00B8; // 8,6,5,4
    localparam logic [63:0] c_tap_mask_16 = 64'h0000_0000_0000_B400; // 16,14,13,11
    localparam logic [63:0] c_tap_mask_32 = 64'h0000_0000_8020_0003; // 32,22,2,1
    localparam logic [63:0] c_tap_mask_64 = 64'hD800_0000_0000_0000; // 64,63,61,60

    // State forced in place of all-zero when the guard is built in.
    localparam logic [63:0] c_zero_guard_value = 64'd1;

    // Returns the tap mask for width n, or 0 for an unsupported width.
    // The top module refuses to elaborate for unsupported widths.
    function automatic logic [63:0] tap_mask(input int n);
        case (n)
            8:       return c_tap_mask_8;
            16:      return c_tap_mask_16;
            32:      return c_tap_mask_32;
            64:      return c_tap_mask_64;
            default: return 64'd0;
        endcase
    endfunction

    function automatic bit width_supported(input int n);
        return (n == 8) || (n == 16) || (n == 32) || (n == 64);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_if.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_if
// Description : Data interface of the LFSR.
//               seed     - value loaded into the register while rst is high
//               rand_out - current register state
//               The master modport drives seed and reads rand_out.
//               The slave modport is the LFSR side.
// Revision    : 1.0 - initial release
// ============================================================================
interface lfsr_if #(
    parameter int N = 16
) ();
    logic [N-1:0] seed;
    logic [N-1:0] rand_out;

    modport master (output seed, input  rand_out);
    modport slave  (input  seed, output rand_out);
endinterface
`default_nettype wire

// File: rtl/lfsr_next.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_next
// Description : Combinational next-state logic for a Fibonacci LFSR.
//               The state shifts toward the MSB, and the new LSB is the XOR
//               of the tap bits.
// Ports       : i_state [N-1:0] - current state
//               o_next  [N-1:0] - state after one step
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int N = 16
) (
    input  wire logic [N-1:0] i_state,
    output logic      [N-1:0] o_next
);

    localparam logic [63:0] c_mask = tap_mask(N);

    logic w_feedback;

    // The all-zero state maps to itself, because no tap can produce a 1.
    assign w_feedback = ^(i_state & c_mask[N-1:0]);
    assign o_next     = {i_state[N-2:0], w_feedback};

endmodule
`default_nettype wire

// File: rtl/lfsr.sv
`default_nettype none
// ============================================================================
// Module      : lfsr
// Description : Free-running maximal-length Fibonacci LFSR.
//               The register width is N = WORD_WIDTH/2, and N must be
//               8, 16, 32 or 64.
//               While rst is high, each clock edge loads seed.
//               Otherwise the register advances one step on every edge.
// Ports       : clk - clock, rising edge
//               rst - synchronous, active-high reset / seed load
//               bus - lfsr_if.slave (seed in, rand_out out)
// Config      : LFSR_ZERO_GUARD_EN - when defined, a zero seed loads 1.
//               Any all-zero state also recovers to 1 on the next edge.
//               When undefined, zero is a lock-up state.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr
    import lfsr_pkg::*;
#(
    parameter int WORD_WIDTH = 32
) (
    input  wire logic clk,
    input  wire logic rst,
    lfsr_if.slave     bus
);

    localparam int N = WORD_WIDTH / 2;

    if ((WORD_WIDTH % 2 != 0) || !width_supported(N)) begin : g_bad_width
        $fatal(1, "lfsr: WORD_WIDTH=%0d gives unsupported LFSR width %0d",
               WORD_WIDTH, N);
    end

    logic [N-1:0] r_state;
    logic [N-1:0] w_next;
    logic [N-1:0] w_load;
    logic [N-1:0] w_step;

    lfsr_next #(.N(N)) u_next (
        .i_state (r_state),
        .o_next  (w_next)
    );

`ifdef LFSR_ZERO_GUARD_EN
    localparam logic [N-1:0] c_guard = c_zero_guard_value[N-1:0];

    assign w_load = (bus.seed == '0) ? c_guard : bus.seed;
    assign w_step = (r_state  == '0) ? c_guard : w_next;
`else
    assign w_load = bus.seed;
    assign w_step = w_next;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= w_load;
        end else begin
            r_state <= w_step;
        end
    end

    // rand_out comes straight from the register, so seed never reaches it
    // combinationally.
    assign bus.rand_out = r_state;

endmodule
`default_nettype wire

// File: tb/tb_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : tb_lfsr
// Description : Directed self-checking bench for lfsr.
//               It drives one N=16 instance (WORD_WIDTH=32) and one
//               N=8 instance (WORD_WIDTH=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr;

    logic clk = 1'b0;
    logic rst16;
    logic rst8;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    lfsr_if #(.N(16)) u_if16 ();
    lfsr_if #(.N(8))  u_if8  ();

    lfsr #(.WORD_WIDTH(32)) u_dut16 (
        .clk (clk),
        .rst (rst16),
        .bus (u_if16.slave)
    );

    lfsr #(.WORD_WIDTH(16)) u_dut8 (
        .clk (clk),
        .rst (rst8),
        .bus (u_if8.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    initial begin
        int first16;
        int first8;

        first16 = 0;
        first8  = 0;

        // Reset load.
        rst16 = 1'b1;
        u_if16.seed = 16'hA65A;
        rst8  = 1'b1;
        u_if8.seed  = 8'h01;
        tick();
        check("reset_seed16", u_if16.rand_out, 16'hA65A);
        check("reset_seed8", {8'h00, u_if8.rand_out}, 16'h0001);

        // First steps after release.
        rst16 = 1'b0;
        tick();
        check("step1", u_if16.rand_out, 16'h4CB5);
        tick();
        check("step2", u_if16.rand_out, 16'h996B);

        // Changing seed while rst is low has no effect.
        u_if16.seed = 16'hFFFF;
        tick();
        check("seed_ignored", u_if16.rand_out, 16'h32D6);

        // Reset in mid-sequence reloads, and stepping restarts from the seed.
        rst16 = 1'b1;
        u_if16.seed = 16'h1234;
        tick();
        check("mid_reset", u_if16.rand_out, 16'h1234);
        rst16 = 1'b0;
        tick();
        check("restart1", u_if16.rand_out, 16'h2469);
        tick();
        check("restart2", u_if16.rand_out, 16'h48D2);

        // Holding rst high keeps reloading the seed.
        rst16 = 1'b1;
        u_if16.seed = 16'hA65A;
        tick();
        check("hold_rst1", u_if16.rand_out, 16'hA65A);
        tick();
        check("hold_rst2", u_if16.rand_out, 16'hA65A);
        tick();
        check("hold_rst3", u_if16.rand_out, 16'hA65A);

        // Full-period check for both widths, released on the same edge.
        rst16 = 1'b0;
        rst8  = 1'b0;
        for (int i = 1; i <= 70000; i++) begin
            tick();
            if (i == 1) begin
                check("period_step1_16", u_if16.rand_out, 16'h4CB5);
                check("period_step1_8", {8'h00, u_if8.rand_out}, 16'h0002);
            end
            if (first16 == 0 && u_if16.rand_out == 16'hA65A) first16 = i;
            if (first8 == 0 && u_if8.rand_out == 8'h01) first8 = i;
            if (first16 != 0 && first8 != 0) break;
        end
        check("period16", first16[15:0], 16'd65535);
        check("period8", first8[15:0], 16'd255);

        // Zero seed.
        rst16 = 1'b1;
        u_if16.seed = 16'h0000;
        tick();
`ifdef LFSR_ZERO_GUARD_EN
        check("zero_seed_load", u_if16.rand_out, 16'h0001);
        rst16 = 1'b0;
        tick();
        check("zero_seed_step1", u_if16.rand_out, 16'h0002);
        tick();
        check("zero_seed_step2", u_if16.rand_out, 16'h0004);
`else
        check("zero_seed_load", u_if16.rand_out, 16'h0000);
        rst16 = 1'b0;
        tick();
        check("zero_lock1", u_if16.rand_out, 16'h0000);
        tick();
        check("zero_lock2", u_if16.rand_out, 16'h0000);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lfsr.md
LFSR -- requirements
Module: lfsr

Interface
REQ-001 Parameter WORD_WIDTH, default 32, datapath word width; LFSR width N = WORD_WIDTH/2 SHALL be used for all data ports.
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge only.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 seed  input  N  initial state loaded during reset.
REQ-005 rand_out  output  N  current LFSR state, driven directly from the state register.

Function
REQ-006 Register type: Fibonacci LFSR, shift toward MSB; new LSB = XOR of tap bits; state[N-1:1] <= state[N-2:0].
REQ-007 Taps (1-based polynomial exponents): N=8: 8,6,5,4; N=16: 16,14,13,11; N=32: 32,22,2,1; N=64: 64,63,61,60.
REQ-008 Each listed polynomial is maximal-length; period from any nonzero state SHALL be 2^N-1.
REQ-009 N not in {8,16,32,64}, or WORD_WIDTH odd: elaboration SHALL fail with a fatal message.
REQ-010 rst low: state SHALL advance exactly one step per rising clk edge; no enable, no stall.
REQ-011 rand_out SHALL be registered; latency from state update to output is zero cycles; no combinational path from seed to rand_out.
REQ-012 seed SHALL be sampled only on edges where rst is high; changes while rst is low SHALL have no effect.
REQ-013 State all-zero SHALL be a fixed point (0 -> 0) unless the guard in REQ-017 is compiled in.

Reset
REQ-014 On a rising clk edge with rst high, state SHALL load seed (subject to REQ-017); rand_out equals seed from that edge.
REQ-015 Reset SHALL take precedence over stepping; asserting rst mid-sequence SHALL reload seed at the next edge.
REQ-016 Holding rst high for several cycles SHALL keep re-loading seed; stepping resumes on the first edge with rst low.

Configuration
REQ-017 Macro LFSR_ZERO_GUARD_EN defined: a seed of 0 SHALL load the constant 1; if state is ever all-zero at a non-reset edge, the next state SHALL be 1.
REQ-018 Macro not defined: seed is loaded verbatim; zero state locks up per REQ-013.

Structure
REQ-019 Package lfsr_pkg SHALL hold the tap table, a function returning the tap mask for N, and the zero-guard constant (1).
REQ-020 One combinational sub-module lfsr_next (state in, next state out, parameter N) SHALL compute the feedback and shift.
REQ-021 The top SHALL contain only the state register, the reset/seed mux, and the zero guard.

Verification
REQ-022 WORD_WIDTH=32, seed=16'hA65A, rst high 1 edge -> rand_out=16'hA65A.
REQ-023 Then rst low: next two edges -> rand_out=16'h4CB5, then 16'h996B.
REQ-024 N=16, nonzero seed, run 65535 steps -> state returns to seed, not earlier.
REQ-025 Assert rst mid-sequence with seed=16'h1234 -> rand_out=16'h1234 at that edge; stepping restarts from it.
REQ-026 seed=0: with LFSR_ZERO_GUARD_EN, rand_out=1 after reset, then 16'h0002; without the macro, rand_out stays 0.
REQ-027 WORD_WIDTH=16 (N=8), seed=8'h01 -> period 255 confirmed; WORD_WIDTH=20 -> elaboration fatal.
